// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, access-size encoding and the
// load/store decode helpers used by the memory stage.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    typedef struct packed {
        logic      load;
        logic      store;
        acc_size_e size;
    } mem_op_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

    function automatic mem_op_t decode_op(input logic [5:0] op);
        mem_op_t d;
        d = '{load: 1'b0, store: 1'b0, size: SZ_W};
        case (op)
            OP_LB, OP_LBU: begin d.load  = 1'b1; d.size = SZ_B; end
            OP_LH, OP_LHU: begin d.load  = 1'b1; d.size = SZ_H; end
            OP_LW:         begin d.load  = 1'b1; d.size = SZ_W; end
            OP_SB:         begin d.store = 1'b1; d.size = SZ_B; end
            OP_SH:         begin d.store = 1'b1; d.size = SZ_H; end
            OP_SW:         begin d.store = 1'b1; d.size = SZ_W; end
            default:       ;
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return ~a[0];
            default: return a == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Request/acknowledge sequencer for the data bus: IDLE/BUSY FSM with a
// wait-state counter that abandons the access after TIMEOUT busy cycles.
module mem_bus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic access,
    input  logic Ack,
    output logic req,
    output logic stall,
    output logic done,
    output logic timeout,
    output logic bus_err
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_e     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Ack beats timeout in the final busy cycle, so req stays up there
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                req = access;
                if (access && !Ack) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 8'd1;
                end
            end
            BUSY: begin
                if (Ack) begin
                    req       = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_CNT) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    req     = 1'b1;
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done    = req && Ack;
    assign stall   = req && !Ack;
    assign bus_err = timeout;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM register, load/store decode, byte-lane steering
// and the data-bus handshake that freezes the upstream pipeline.
module mem_stage
    import mips_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PC_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] Res_in,
    input  logic [31:0] WData_in,
    output logic        Req,
    output logic        We,
    output logic [31:0] Addr,
    output logic [3:0]  BE,
    output logic [31:0] WData,
    input  logic [31:0] RData,
    input  logic        Ack,
    output logic        Stall,
    output logic        AddrErr,
    output logic        BusErr,
    output logic [31:0] Res,
    output logic [31:0] MemRData,
    output logic [31:0] PC,
    output logic [31:0] instr
);

    logic [31:0] pc_q, instr_q, res_q, wdata_q;
    mem_op_t     dec;
    logic        mem_op, misalign, access;
    logic        req, stall, done, timeout, bus_err;
    logic [3:0]  be_raw;
    logic [31:0] lanes;
    bus_req_t    breq;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q    <= '0;
            instr_q <= '0;
            res_q   <= '0;
            wdata_q <= '0;
        end else if (!Stall) begin
            pc_q    <= PC_in;
            instr_q <= instr_in;
            res_q   <= Res_in;
            wdata_q <= WData_in;
        end
    end

    assign dec      = decode_op(instr_q[31:26]);
    assign mem_op   = dec.load || dec.store;
    assign misalign = mem_op && !is_aligned(dec.size, res_q[1:0]);
    assign access   = mem_op && !misalign;

    mem_bus_ctrl #(.TIMEOUT(TIMEOUT)) u_bus_ctrl (
        .Clk     (Clk),
        .Rst     (Rst),
        .access  (access),
        .Ack     (Ack),
        .req     (req),
        .stall   (stall),
        .done    (done),
        .timeout (timeout),
        .bus_err (bus_err)
    );

    // Store data is replicated across lanes; BE selects the live bytes
    always_comb begin
        be_raw = 4'b1111;
        lanes  = wdata_q;
        case (dec.size)
            SZ_B: begin
                be_raw = 4'b0001 << res_q[1:0];
                lanes  = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                be_raw = 4'b0011 << {res_q[1], 1'b0};
                lanes  = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        breq = '0;
        if (req) begin
            breq.we    = dec.store;
            breq.addr  = {res_q[31:2], 2'b00};
            breq.be    = be_raw;
            breq.wdata = dec.store ? lanes : '0;
        end
    end

    assign Req     = req;
    assign We      = breq.we;
    assign Addr    = breq.addr;
    assign BE      = breq.be;
    assign WData   = breq.wdata;
    assign Stall   = stall;
    assign AddrErr = misalign;
    assign BusErr  = bus_err;

    assign Res      = res_q;
    assign PC       = pc_q;
    assign instr    = (Stall || misalign) ? '0 : instr_q;
    assign MemRData = (dec.load && done)    ? RData    :
                      (dec.load && timeout) ? ERR_DATA : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random load/store traffic,
// a latency-driven bus responder and a scoreboard monitor.
module tb_mem_stage;

    localparam int          TIMEOUT  = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        Clk, Rst;
    logic [31:0] PC_in, instr_in, Res_in, WData_in;
    logic        Req, We, Ack, Stall, AddrErr, BusErr;
    logic [31:0] Addr, WData, RData, Res, MemRData, PC, instr;
    logic [3:0]  BE;

    mem_stage #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .Clk(Clk), .Rst(Rst), .PC_in(PC_in), .instr_in(instr_in),
        .Res_in(Res_in), .WData_in(WData_in), .Req(Req), .We(We),
        .Addr(Addr), .BE(BE), .WData(WData), .RData(RData), .Ack(Ack),
        .Stall(Stall), .AddrErr(AddrErr), .BusErr(BusErr), .Res(Res),
        .MemRData(MemRData), .PC(PC), .instr(instr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] instr, pc, res, addr, wdata, instr_wb, memr;
        logic [3:0]  be;
        logic        acc, mis, to, req, we;
        int          stall;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } rsp_t;

    exp_t sbq[$];
    rsp_t rspq[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference: access size/offset arithmetic straight from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, pc, res, rt,
                                   input int lat, input logic [31:0] rd);
        exp_t e;
        int   sz, off;
        bit   ld, st;
        sz = 0; ld = 0; st = 0;
        case (int'(ins[31:26]))
            'h20, 'h24: begin sz = 1; ld = 1; end
            'h21, 'h25: begin sz = 2; ld = 1; end
            'h23:       begin sz = 4; ld = 1; end
            'h28:       begin sz = 1; st = 1; end
            'h29:       begin sz = 2; st = 1; end
            'h2B:       begin sz = 4; st = 1; end
            default:    ;
        endcase
        off = int'(res[1:0]);
        e.instr = ins; e.pc = pc; e.res = res;
        e.mis   = (sz != 0) ? ((off % sz) != 0) : 1'b0;
        e.acc   = (sz != 0) && !e.mis;
        e.to    = e.acc && (lat > TIMEOUT);
        e.stall = e.acc ? ((lat < TIMEOUT) ? lat : TIMEOUT) : 0;
        e.req   = e.acc && !e.to;
        e.addr  = res - 32'(off);
        e.we    = st;
        e.be    = '0;
        e.wdata = '0;
        for (int b = 0; b < 4; b++) begin
            if (e.acc && b >= off && b < off + sz) e.be[b] = 1'b1;
            if (st) e.wdata[8*b +: 8] = rt[8*(b % sz) +: 8];
        end
        e.instr_wb = e.mis ? 32'd0 : ins;
        e.memr     = (ld && e.acc) ? (e.to ? ERR_DATA : rd) : 32'd0;
        return e;
    endfunction

    // Drive one instruction, wait for the stage to accept it, then expect it
    task automatic issue(input logic [31:0] ins, pc, res, rt,
                         input int lat, input logic [31:0] rd);
        exp_t e;
        int   n;
        logic st;
        e = model(ins, pc, res, rt, lat, rd);
        PC_in = pc; instr_in = ins; Res_in = res; WData_in = rt;
        if (e.acc) rspq.push_back('{lat, rd});
        n = 0;
        do begin
            @(negedge Clk); st = Stall;
            @(posedge Clk); #1;
            n++;
        end while (st && n < 64);
        chk1("capture_wait", st, 1'b0);
        sbq.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_req"}, Req, 1'b0);
        chk1({tag, "_we"}, We, 1'b0);
        chk32({tag, "_addr"}, Addr, 32'd0);
        chk32({tag, "_be"}, {28'd0, BE}, 32'd0);
        chk32({tag, "_wdata"}, WData, 32'd0);
        chk1({tag, "_stall"}, Stall, 1'b0);
        chk1({tag, "_addrerr"}, AddrErr, 1'b0);
        chk1({tag, "_buserr"}, BusErr, 1'b0);
        chk32({tag, "_res"}, Res, 32'd0);
        chk32({tag, "_memrdata"}, MemRData, 32'd0);
        chk32({tag, "_pc"}, PC, 32'd0);
        chk32({tag, "_instr"}, instr, 32'd0);
    endtask

    // Bus responder: acks the k-th request cycle per the planned latency
    int   rsp_k;
    bit   rsp_active;
    rsp_t rsp_cur;
    initial begin
        Ack = 1'b0; RData = '0; rsp_active = 0; rsp_k = 0;
        forever begin
            @(posedge Clk); #1;
            Ack = 1'b0; RData = $urandom;
            #1;
            if (!Rst) begin
                rsp_active = 0;
                rspq.delete();
            end else begin
                if (!rsp_active) begin
                    if (Req) begin
                        if (rspq.size() == 0) begin
                            chk1("unplanned_req", Req, 1'b0);
                        end else begin
                            rsp_cur = rspq.pop_front();
                            rsp_active = 1; rsp_k = 0;
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        Ack = 1'b1;
                    end
                end else begin
                    rsp_k++;
                end
                if (rsp_active) begin
                    if (rsp_k == rsp_cur.lat) begin
                        Ack = 1'b1; RData = rsp_cur.rdata; rsp_active = 0;
                    end else if (rsp_k >= TIMEOUT) begin
                        rsp_active = 0;
                    end
                end
            end
        end
    end

    // Monitor: stall cycles of the head item, then its single retire cycle
    exp_t me;
    int   scyc = 0;
    always @(negedge Clk) begin
        if (!Rst) begin
            sbq.delete();
            scyc = 0;
        end else if (sbq.size() > 0) begin
            me = sbq[0];
            if (scyc < me.stall) begin
                chk1("stall_hi", Stall, 1'b1);
                chk1("req_hold", Req, 1'b1);
                chk32("addr_hold", Addr, me.addr);
                chk32("be_hold", {28'd0, BE}, {28'd0, me.be});
                chk1("we_hold", We, me.we);
                chk32("wdata_hold", WData, me.wdata);
                chk32("instr_bubble", instr, 32'd0);
                scyc++;
                if (!Stall) begin sbq.delete(0); scyc = 0; end
            end else begin
                chk1("stall_lo", Stall, 1'b0);
                chk1("req", Req, me.req);
                if (me.req) begin
                    chk32("addr", Addr, me.addr);
                    chk32("be", {28'd0, BE}, {28'd0, me.be});
                    chk1("we", We, me.we);
                    chk32("wdata", WData, me.wdata);
                end
                chk32("instr_wb", instr, me.instr_wb);
                chk32("res", Res, me.res);
                chk32("pc", PC, me.pc);
                chk32("memrdata", MemRData, me.memr);
                chk1("addrerr", AddrErr, me.mis);
                chk1("buserr", BusErr, me.to);
                sbq.delete(0);
                scyc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] ops [12];
    initial begin
        int n;
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                6'h00, 6'h08, 6'h0F, 6'h23};
        Rst = 1'b0;
        PC_in = '1; instr_in = {6'h23, 26'h1}; Res_in = 32'h10; WData_in = '1;
        #3;
        chk_all_zero("reset");
        instr_in = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;

        issue({6'h2B, 26'h0}, 32'h0000_1000, 32'h100, 32'hCAFE_BABE, 0, 0);
        issue({6'h23, 26'h1}, 32'h0000_1004, 32'h204, 32'h0, 3, 32'h1234_5678);
        issue({6'h28, 26'h2}, 32'h0000_1008, 32'h103, 32'hAB, 1, 0);
        issue({6'h29, 26'h3}, 32'h0000_100C, 32'h102, 32'h1234, 0, 0);
        issue({6'h23, 26'h4}, 32'h0000_1010, 32'h102, 32'h0, 0, 0);
        issue({6'h23, 26'h5}, 32'h0000_1014, 32'h208, 32'h0, TIMEOUT + 3, 0);
        issue({6'h25, 26'h6}, 32'h0000_1018, 32'h20A, 32'h0, TIMEOUT, 32'h0000_BEEF);
        issue({6'h24, 26'h7}, 32'h0000_101C, 32'h5, 32'h0, 2, 32'h0000_0077);

        issue({6'h23, 26'h8}, 32'h0000_1020, 32'h300, 32'h0, TIMEOUT + 5, 0);
        @(negedge Clk);
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1 chk_all_zero("midreset");
        instr_in = '0;
        @(posedge Clk);
        @(negedge Clk);
        #2 Rst = 1'b1;
        @(posedge Clk); #1;
        issue({6'h23, 26'h9}, 32'h0000_2000, 32'h40, 32'h0, 1, 32'h55AA_55AA);

        for (int i = 0; i < 300; i++) begin
            issue({ops[$urandom_range(0, 11)], 26'($urandom)}, $urandom, $urandom,
                  $urandom, $urandom_range(0, TIMEOUT + 2), $urandom);
        end

        instr_in = '0;
        n = 0;
        while (sbq.size() > 0 && n < 64) begin
            @(posedge Clk);
            n++;
        end
        chk32("drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, sitting between EX and WB.
- Contains the EX/MEM stage register and decodes load/store instructions.
- Drives a request/acknowledge data-memory bus with byte enables and a timeout.
- Stalls upstream stages while an access is outstanding, and presents Res/MemRData/PC/instr to WB, which registers them and performs load extension.

Parameters:
- TIMEOUT, 16, maximum BUSY cycles without Ack before the access is aborted (range 1..255).
- ERR_DATA, 32'h0000_0000, value returned on MemRData for a load that timed out.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- PC_in  in  32  PC of the instruction leaving EX.
- instr_in  in  32  instruction leaving EX.
- Res_in  in  32  ALU result; the effective address for loads and stores.
- WData_in  in  32  store data (forwarded rt value).
- Req  out  1  bus request, held until Ack or timeout.
- We  out  1  write strobe, valid with Req.
- Addr  out  32  word address {Res[31:2],2'b00}.
- BE  out  4  byte enables.
- WData  out  32  store data replicated to lanes.
- RData  in  32  bus read data, valid with Ack.
- Ack  in  1  bus completion, 1-cycle pulse.
- Stall  out  1  freeze PC/IF/ID/EX registers.
- AddrErr  out  1  misaligned load/store (AdEL/AdES), 1-cycle pulse.
- BusErr  out  1  access timed out, 1-cycle pulse.
- Res  out  32  registered ALU result to WB.
- MemRData  out  32  raw load word to WB.
- PC  out  32  registered PC to WB.
- instr  out  32  instruction to WB; 0 (nop) while stalled.

Behaviour:
- Reset (Rst=0, async): stage register cleared to 0 (instr=0 is a nop); FSM to IDLE; counter cleared. All outputs 0.
- Stage register: on a rising edge with Stall=0, captures PC_in, instr_in, Res_in and WData_in. With Stall=1 it holds.
- Decode on instr[31:26]:
  - lb 20, lbu 24, lh 21, lhu 25, lw 23: loads.
  - sb 28, sh 29, sw 2B: stores. All other opcodes are non-memory.
- Alignment: half requires Res[0]=0; word requires Res[1:0]=0.
  - A misaligned access raises AddrErr for one cycle and issues no Req.
  - The instruction is passed to WB as 0, so it performs no register write.
- BE:
  - byte: 4'b0001<<Res[1:0].
  - half: 4'b0011<<{Res[1],1'b0}.
  - word: 4'b1111.
  - Loads use the same BE.
- WData: sb replicates {4{rt[7:0]}}; sh replicates {2{rt[15:0]}}; sw passes through.
- FSM:
  - IDLE: Req is asserted combinationally when the held instruction is an aligned load/store.
    - If Ack arrives the same cycle, the access completes in zero-wait and the FSM stays in IDLE.
    - Otherwise the FSM goes to BUSY and the counter loads 1.
  - BUSY: Req, Addr, BE, We and WData are held stable and the counter increments.
    - On Ack, go to IDLE.
    - When counter==TIMEOUT with no Ack, pulse BusErr in that cycle, drop Req, and go to IDLE.
    - An Ack arriving in the same cycle as timeout wins, and no BusErr is raised.
- Stall = Req && !Ack && !timeout. Completion deasserts Stall combinationally, so the next instruction is captured on the same edge. No access is ever reissued.
- WB outputs:
  - Res and PC pass the registered values through.
  - instr = Stall ? 0 : instr_q.
  - MemRData = RData on a load completion cycle, ERR_DATA on a load timeout cycle, and 0 otherwise.
- An Ack seen in IDLE with no Req is ignored.
- Reset mid-access drops Req immediately. The bus must tolerate an abandoned request.

Decomposition:
- Shared package mips_pkg holds the opcode constants (OP_LB..OP_SW) and the access-size encoding (SZ_B/SZ_H/SZ_W).
- One sub-module, mem_bus_ctrl, contains the IDLE/BUSY FSM, the timeout counter, and the Req/Stall/BusErr logic.
- Decode, the stage register and lane steering stay in mem_stage.

Test Plan:
- Zero-wait path: sw with Res_in=0x100 and rt=0xCAFEBABE, Ack returned with Req.
  - Expect Req/We=1, Addr=0x100, BE=1111, WData=0xCAFEBABE, Stall=0, and instr passed to WB the next cycle.
- Wait states: lw at 0x204 with Ack delayed 3 cycles and RData=0x12345678.
  - Expect Stall=1 for 3 cycles and instr=0 to WB during them.
  - On the Ack cycle, expect MemRData=0x12345678 and instr=lw.
- sb at 0x103 with rt=0xAB: expect BE=1000 and WData=0xABABABAB. sh at 0x102: expect BE=1100.
- lw at 0x102: expect AddrErr pulse, Req=0, Stall=0, and instr=0 to WB.
- lw with no Ack and TIMEOUT=4: expect Stall for 4 cycles, then BusErr=1 and MemRData=ERR_DATA, then back to IDLE.
- Assert Rst low in BUSY: expect Req, Stall and all outputs 0 immediately. After release, a new lw issues normally.
